// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the multi-channel frequency divider.
// Channel state encoding, default sizes, channel-select width.
package freq_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } ch_st_e;

  localparam int DEF_CW  = 8;
  localparam int DEF_NCH = 4;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freq_div_if.sv
// Config write port of the divider scheduler.
// valid/ready handshake carrying channel, divisor and enable.
interface freq_div_if
  import freq_div_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = DEF_CW
);

  localparam int CHW = chan_w(NCH);

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_en;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_en,
    output cfg_ready
  );

endinterface

// File: rtl/freq_div_ch.sv
// One divider channel: FSM, counter, shadow divisor, divided clock.
// A new divisor written while running is applied only at terminal count.
module freq_div_ch
  import freq_div_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [CW-1:0] div_i,
  input  logic          en_i,
  input  logic          sync_i,
  output logic          tick_o,
  output logic          clk_o,
  output logic          pend_o
);

  ch_st_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] sdiv_q, sdiv_d;
  logic          sen_q, sen_d;
  logic          clk_q, clk_d;
  logic          go;
  logic          tc;

  // a zero divisor is a stop request
  assign go     = en_i & (div_i != '0);
  assign tc     = (st_q != ST_IDLE) &&
                  (cnt_q == div_q - CW'(1));
  assign tick_o = tc & ~sync_i;
  assign clk_o  = clk_q;
  assign pend_o = (st_q == ST_PEND);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    sdiv_d = sdiv_q;
    sen_d  = sen_q;
    clk_d  = clk_q;
    if (sync_i) begin
      if (st_q != ST_IDLE) begin
        cnt_d = '0;
        clk_d = 1'b0;
      end
      if (st_q == ST_PEND) begin
        st_d   = sen_q ? ST_RUN : ST_IDLE;
        div_d  = sen_q ? sdiv_q : div_q;
        sdiv_d = '0;
        sen_d  = 1'b0;
      end
      if (wr_i) begin
        cnt_d = '0;
        st_d  = go ? ST_RUN : ST_IDLE;
        if (go) div_d = div_i;
      end
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (wr_i && go) begin
            div_d = div_i;
            st_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          cnt_d = tc ? '0 : cnt_q + CW'(1);
          if (tc) clk_d = ~clk_q;
          if (wr_i) begin
            sdiv_d = div_i;
            sen_d  = go;
            st_d   = ST_PEND;
          end
        end
        ST_PEND: begin
          cnt_d = tc ? '0 : cnt_q + CW'(1);
          if (tc) begin
            clk_d  = ~clk_q;
            st_d   = sen_q ? ST_RUN : ST_IDLE;
            div_d  = sen_q ? sdiv_q : div_q;
            sdiv_d = '0;
            sen_d  = 1'b0;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      div_q  <= '0;
      sdiv_q <= '0;
      sen_q  <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      sdiv_q <= sdiv_d;
      sen_q  <= sen_d;
      clk_q  <= clk_d;
    end
  end

endmodule

// File: rtl/freq_div_sched.sv
// Multi-channel programmable divider: channel decode and ready mux.
// Optional FREQ_DIV_SYNC_EN adds sync_i to re-phase all channels.
module freq_div_sched
  import freq_div_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = DEF_CW
) (
  input  logic           clk,
  input  logic           reset,
  freq_div_if.slave      cfg,
`ifdef FREQ_DIV_SYNC_EN
  input  logic           sync_i,
`endif
  output logic [NCH-1:0] tick_o,
  output logic [NCH-1:0] clk_o
);

  localparam int CHW = chan_w(NCH);

  logic [NCH-1:0] pend;
  logic [NCH-1:0] wr;
  logic           rdy;
  logic           sync;

`ifdef FREQ_DIV_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  // out-of-range channels match nothing: ready stays 1, write dropped
  always_comb begin
    rdy = 1'b1;
    wr  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg.cfg_ch == CHW'(i)) rdy = ~pend[i];
    end
    for (int i = 0; i < NCH; i++) begin
      wr[i] = cfg.cfg_valid & rdy &
              (cfg.cfg_ch == CHW'(i));
    end
  end

  assign cfg.cfg_ready = rdy;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    freq_div_ch #(
      .CW(CW)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .wr_i   (wr[g]),
      .div_i  (cfg.cfg_div),
      .en_i   (cfg.cfg_en),
      .sync_i (sync),
      .tick_o (tick_o[g]),
      .clk_o  (clk_o[g]),
      .pend_o (pend[g])
    );
  end

endmodule
